// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI command sequencer: completion codes,
// FSM encoding and engine response field layout.
package esdi_pkg;

    localparam logic [2:0] DONE_OK      = 3'd0;
    localparam logic [2:0] DONE_SER_TMO = 3'd1;
    localparam logic [2:0] DONE_PARITY  = 3'd2;
    localparam logic [2:0] DONE_CC_TMO  = 3'd3;
    localparam logic [2:0] DONE_NOT_RDY = 3'd4;
    localparam logic [2:0] DONE_ATTN    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_RESP  = 3'd2,
        ST_WAIT_CC    = 3'd3,
        ST_STAT_ISSUE = 3'd4,
        ST_STAT_RESP  = 3'd5,
        ST_DONE       = 3'd6
    } seq_state_e;

    localparam int RESP_TMO_BIT  = 17;
    localparam int RESP_PAR_BIT  = 16;
    localparam int RESP_DATA_MSB = 15;
    localparam int RESP_DATA_LSB = 0;

    // Serial timeout outranks a parity error reported in the same response.
    function automatic logic [2:0] resp_err_code(input logic [17:0] resp);
        logic [2:0] code;
        if (resp[RESP_TMO_BIT]) begin
            code = DONE_SER_TMO;
        end else if (resp[RESP_PAR_BIT]) begin
            code = DONE_PARITY;
        end else begin
            code = DONE_OK;
        end
        return code;
    endfunction

endpackage

// File: rtl/esdi_line_sync.sv
// Two-flop synchroniser for asynchronous active-low drive lines; resets to
// all-ones so every line reads as inactive until real samples arrive.
module esdi_line_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/esdi_cmd_sequencer.sv
// Runs one ESDI host command through the serial engine, optionally waits for
// COMMAND COMPLETE, follows ATTENTION with a status query, returns one record.
module esdi_cmd_sequencer
    import esdi_pkg::*;
#(
    parameter int unsigned CC_TIMEOUT  = 50_000_000,
    parameter logic [15:0] STATUS_WORD = 16'h0000
) (
    input  logic        csr_aclk,
    input  logic        csr_areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_word,
    input  logic        req_is_query,
    input  logic        req_wait_cc,
    output logic        eng_word_valid,
    input  logic        eng_word_ready,
    output logic [16:0] eng_word,
    input  logic        eng_resp_valid,
    input  logic [17:0] eng_resp,
    input  logic        esdi_command_complete_n,
    input  logic        esdi_attention_n,
    input  logic        esdi_ready_n,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [2:0]  done_code,
    output logic [15:0] done_data,
    output logic [15:0] done_status,
    output logic        busy
);

    localparam int CNT_W = $clog2(CC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CC_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_cc_q, wait_cc_d;
    logic [16:0]      eng_word_q, eng_word_d;
    logic [2:0]       done_code_q, done_code_d;
    logic [15:0]      done_data_q, done_data_d;
    logic [15:0]      done_status_q, done_status_d;
    logic             req_ready_q, eng_word_valid_q, done_valid_q, busy_q;
    logic [2:0]       lines_s;
    logic             cc_s, attn_s, rdy_s;

    esdi_line_sync #(.W(3)) u_line_sync (
        .clk_i (csr_aclk),
        .rst_i (csr_areset),
        .d_i   ({esdi_ready_n, esdi_attention_n, esdi_command_complete_n}),
        .q_o   (lines_s)
    );

    assign cc_s   = ~lines_s[0];
    assign attn_s = ~lines_s[1];
    assign rdy_s  = ~lines_s[2];

    // Next-state and record-field logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_cc_d     = wait_cc_q;
        eng_word_d    = eng_word_q;
        done_code_d   = done_code_q;
        done_data_d   = done_data_q;
        done_status_d = done_status_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wait_cc_d     = req_wait_cc;
                    done_code_d   = DONE_OK;
                    done_data_d   = 16'h0000;
                    done_status_d = 16'h0000;
                    if (!rdy_s) begin
                        done_code_d = DONE_NOT_RDY;
                        state_d     = ST_DONE;
                    end else begin
                        eng_word_d = {req_is_query, req_word};
                        state_d    = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE, ST_STAT_ISSUE: begin
                if (eng_word_valid_q && eng_word_ready) begin
                    state_d = (state_q == ST_ISSUE) ? ST_WAIT_RESP : ST_STAT_RESP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_RESP: begin
                if (!eng_resp_valid) begin
                    state_d = ST_WAIT_RESP;
                end else if (resp_err_code(eng_resp) != DONE_OK) begin
                    done_code_d = resp_err_code(eng_resp);
                    state_d     = ST_DONE;
                end else begin
                    done_data_d = eng_resp[RESP_DATA_MSB:RESP_DATA_LSB];
                    cnt_d       = '0;
                    state_d     = wait_cc_q ? ST_WAIT_CC : ST_DONE;
                end
            end
            ST_WAIT_CC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (attn_s) begin
                    eng_word_d = {1'b1, STATUS_WORD};
                    state_d    = ST_STAT_ISSUE;
                end else if (cc_s) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    done_code_d = DONE_CC_TMO;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_WAIT_CC;
                end
            end
            ST_STAT_RESP: begin
                if (!eng_resp_valid) begin
                    state_d = ST_STAT_RESP;
                end else if (resp_err_code(eng_resp) != DONE_OK) begin
                    done_code_d = resp_err_code(eng_resp);
                    state_d     = ST_DONE;
                end else begin
                    done_code_d   = DONE_ATTN;
                    done_status_d = eng_resp[RESP_DATA_MSB:RESP_DATA_LSB];
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_valid_q && done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; handshake flags are decoded from state_d
    // so they line up with the state they describe.
    always_ff @(posedge csr_aclk or posedge csr_areset) begin
        if (csr_areset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            wait_cc_q        <= 1'b0;
            eng_word_q       <= 17'h00000;
            done_code_q      <= DONE_OK;
            done_data_q      <= 16'h0000;
            done_status_q    <= 16'h0000;
            req_ready_q      <= 1'b0;
            eng_word_valid_q <= 1'b0;
            done_valid_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wait_cc_q        <= wait_cc_d;
            eng_word_q       <= eng_word_d;
            done_code_q      <= done_code_d;
            done_data_q      <= done_data_d;
            done_status_q    <= done_status_d;
            req_ready_q      <= (state_d == ST_IDLE);
            eng_word_valid_q <= (state_d == ST_ISSUE) || (state_d == ST_STAT_ISSUE);
            done_valid_q     <= (state_d == ST_DONE);
            busy_q           <= (state_d != ST_IDLE);
        end
    end

    assign req_ready      = req_ready_q;
    assign eng_word_valid = eng_word_valid_q;
    assign eng_word       = eng_word_q;
    assign done_valid     = done_valid_q;
    assign done_code      = done_code_q;
    assign done_data      = done_data_q;
    assign done_status    = done_status_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Self-checking bench for esdi_cmd_sequencer: directed vector table, a few
// hand-written corner sequences, then randomized transactions vs a model.
module tb_esdi_cmd_sequencer;

    localparam int unsigned CC_TMO = 128;
    localparam logic [15:0] STAT_W = 16'h0000;
    localparam int M_NONE = 0;
    localparam int M_CC   = 1;
    localparam int M_ATTN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_query, req_wait_cc;
    logic [15:0] req_word;
    logic        eng_word_valid, eng_word_ready;
    logic [16:0] eng_word;
    logic        eng_resp_valid;
    logic [17:0] eng_resp;
    logic        cc_n, attn_n, rdy_n;
    logic        done_valid, done_ready, busy;
    logic [2:0]  done_code;
    logic [15:0] done_data, done_status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    esdi_cmd_sequencer #(.CC_TIMEOUT(CC_TMO), .STATUS_WORD(STAT_W)) dut (
        .csr_aclk                (clk),
        .csr_areset              (rst),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_word                (req_word),
        .req_is_query            (req_is_query),
        .req_wait_cc             (req_wait_cc),
        .eng_word_valid          (eng_word_valid),
        .eng_word_ready          (eng_word_ready),
        .eng_word                (eng_word),
        .eng_resp_valid          (eng_resp_valid),
        .eng_resp                (eng_resp),
        .esdi_command_complete_n (cc_n),
        .esdi_attention_n        (attn_n),
        .esdi_ready_n            (rdy_n),
        .done_valid              (done_valid),
        .done_ready              (done_ready),
        .done_code               (done_code),
        .done_data               (done_data),
        .done_status             (done_status),
        .busy                    (busy)
    );

    typedef struct {
        logic [2:0]  code;
        logic [15:0] data;
        logic [15:0] status;
    } exp_t;

    typedef struct {
        logic [15:0] w;
        bit          q;
        bit          wcc;
        bit          rdy;
        bit          attn_pre;
        int          mode;
        int          dly;
        logic [17:0] r1;
        logic [17:0] r2;
        exp_t        e;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(input logic [15:0] w, input bit q, input bit wcc,
                                 input bit rdy, input bit ap, input int mode, input int dly,
                                 input logic [17:0] r1, input logic [17:0] r2,
                                 input logic [2:0] c, input logic [15:0] d, input logic [15:0] s);
        vec_t v;
        v.w = w; v.q = q; v.wcc = wcc; v.rdy = rdy; v.attn_pre = ap;
        v.mode = mode; v.dly = dly; v.r1 = r1; v.r2 = r2;
        v.e.code = c; v.e.data = d; v.e.status = s;
        return v;
    endfunction

    // Reference outcome of one transaction, straight from the command rules.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.code = 3'd0; e.data = 16'h0000; e.status = 16'h0000;
        if (!v.rdy)          e.code = 3'd4;
        else if (v.r1[17])   e.code = 3'd1;
        else if (v.r1[16])   e.code = 3'd2;
        else begin
            e.data = v.r1[15:0];
            if (v.wcc) begin
                if (v.mode == M_NONE)    e.code = 3'd3;
                else if (v.mode == M_CC) e.code = 3'd0;
                else if (v.r2[17])       e.code = 3'd1;
                else if (v.r2[16])       e.code = 3'd2;
                else begin
                    e.code   = 3'd5;
                    e.status = v.r2[15:0];
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({name, "_done_valid"}, {31'd0, done_valid}, 32'd1);
    endtask

    task automatic wait_eng(input string name);
        int n = 0;
        while (eng_word_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, "_stat_valid"}, {31'd0, eng_word_valid}, 32'd1);
    endtask

    task automatic pulse_resp(input logic [17:0] r);
        eng_resp = r;
        eng_resp_valid = 1'b1;
        tick();
        eng_resp_valid = 1'b0;
    endtask

    task automatic do_txn(input vec_t v, input exp_t e, input string tag);
        int n = 0;
        rdy_n  = !v.rdy;
        attn_n = !v.attn_pre;
        cc_n   = 1'b1;
        repeat (3) tick();
        req_word = v.w; req_is_query = v.q; req_wait_cc = v.wcc; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        if (!v.rdy) begin
            check({tag, "_no_eng"}, {31'd0, eng_word_valid}, 32'd0);
            check({tag, "_nr_done"}, {31'd0, done_valid}, 32'd1);
        end else begin
            check({tag, "_eng_valid"}, {31'd0, eng_word_valid}, 32'd1);
            check({tag, "_eng_word"}, {15'd0, eng_word}, {15'd0, v.q, v.w});
            repeat ($urandom_range(0, 2)) tick();
            eng_word_ready = 1'b1;
            tick();
            eng_word_ready = 1'b0;
            check({tag, "_eng_drop"}, {31'd0, eng_word_valid}, 32'd0);
            repeat ($urandom_range(0, 3)) tick();
            pulse_resp(v.r1);
            if (v.r1[17:16] != 2'b00 || !v.wcc) begin
                check({tag, "_resp_done"}, {31'd0, done_valid}, 32'd1);
            end else if (v.mode == M_NONE) begin
                repeat (CC_TMO - 1) tick();
                check({tag, "_tmo_early"}, {31'd0, done_valid}, 32'd0);
                tick();
                check({tag, "_tmo_exact"}, {31'd0, done_valid}, 32'd1);
            end else begin
                repeat (v.dly) tick();
                if (v.mode == M_CC) begin
                    cc_n = 1'b0;
                end else begin
                    attn_n = 1'b0;
                    wait_eng(tag);
                    check({tag, "_stat_word"}, {15'd0, eng_word}, {15'd0, 1'b1, STAT_W});
                    eng_word_ready = 1'b1;
                    tick();
                    eng_word_ready = 1'b0;
                    attn_n = 1'b1;
                    repeat ($urandom_range(0, 3)) tick();
                    pulse_resp(v.r2);
                end
            end
        end
        wait_done(tag);
        repeat ($urandom_range(0, 3)) tick();
        check({tag, "_hold"}, {31'd0, done_valid}, 32'd1);
        check({tag, "_code"}, {29'd0, done_code}, {29'd0, e.code});
        check({tag, "_data"}, {16'd0, done_data}, {16'd0, e.data});
        check({tag, "_status"}, {16'd0, done_status}, {16'd0, e.status});
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, "_done_drop"}, {31'd0, done_valid}, 32'd0);
        check({tag, "_idle"}, {30'd0, busy, eng_word_valid}, 32'd0);
        cc_n = 1'b1; attn_n = 1'b1; rdy_n = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_eng_valid"}, {31'd0, eng_word_valid}, 32'd0);
        check({tag, "_eng_word"}, {15'd0, eng_word}, 32'd0);
        check({tag, "_done_valid"}, {31'd0, done_valid}, 32'd0);
        check({tag, "_done_code"}, {29'd0, done_code}, 32'd0);
        check({tag, "_done_data"}, {16'd0, done_data}, 32'd0);
        check({tag, "_done_status"}, {16'd0, done_status}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        rst = 1'b1; req_valid = 1'b0; req_word = 16'h0000; req_is_query = 1'b0;
        req_wait_cc = 1'b0; eng_word_ready = 1'b0; eng_resp_valid = 1'b0;
        eng_resp = 18'h00000; cc_n = 1'b1; attn_n = 1'b1; rdy_n = 1'b0; done_ready = 1'b0;

        tbl[0]  = mkv(16'h1123, 1'b0, 1'b0, 1'b1, 1'b0, M_NONE, 0,   18'h00000, 18'h00000, 3'd0, 16'h0000, 16'h0000);
        tbl[1]  = mkv(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, M_NONE, 0,   18'h00A5A, 18'h00000, 3'd0, 16'h0A5A, 16'h0000);
        tbl[2]  = mkv(16'h1040, 1'b0, 1'b1, 1'b1, 1'b0, M_CC,   100, 18'h00000, 18'h00000, 3'd0, 16'h0000, 16'h0000);
        tbl[3]  = mkv(16'h1040, 1'b0, 1'b1, 1'b1, 1'b0, M_NONE, 0,   18'h00000, 18'h00000, 3'd3, 16'h0000, 16'h0000);
        tbl[4]  = mkv(16'h1040, 1'b0, 1'b1, 1'b1, 1'b0, M_ATTN, 20,  18'h00000, 18'h01234, 3'd5, 16'h0000, 16'h1234);
        tbl[5]  = mkv(16'h1123, 1'b0, 1'b0, 1'b0, 1'b0, M_NONE, 0,   18'h00000, 18'h00000, 3'd4, 16'h0000, 16'h0000);
        tbl[6]  = mkv(16'h1123, 1'b0, 1'b0, 1'b1, 1'b0, M_NONE, 0,   18'h20000, 18'h00000, 3'd1, 16'h0000, 16'h0000);
        tbl[7]  = mkv(16'h1123, 1'b0, 1'b0, 1'b1, 1'b0, M_NONE, 0,   18'h10000, 18'h00000, 3'd2, 16'h0000, 16'h0000);
        tbl[8]  = mkv(16'h1040, 1'b0, 1'b1, 1'b1, 1'b0, M_ATTN, 5,   18'h00000, 18'h20000, 3'd1, 16'h0000, 16'h0000);
        tbl[9]  = mkv(16'h8001, 1'b1, 1'b1, 1'b1, 1'b0, M_CC,   10,  18'h0BEEF, 18'h00000, 3'd0, 16'hBEEF, 16'h0000);
        tbl[10] = mkv(16'h8002, 1'b1, 1'b0, 1'b1, 1'b0, M_NONE, 0,   18'h3FFFF, 18'h00000, 3'd1, 16'h0000, 16'h0000);
        tbl[11] = mkv(16'h1123, 1'b0, 1'b0, 1'b1, 1'b1, M_NONE, 0,   18'h00000, 18'h00000, 3'd0, 16'h0000, 16'h0000);
        tbl[12] = mkv(16'h8003, 1'b1, 1'b1, 1'b1, 1'b0, M_ATTN, 0,   18'h00077, 18'h10000, 3'd2, 16'h0077, 16'h0000);

        repeat (3) tick();
        check_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst0_first_edge_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i], tbl[i].e, $sformatf("vec%0d", i));
        end

        // Engine response while idle must be ignored.
        pulse_resp(18'h3FFFF);
        tick();
        check("idle_resp_done", {31'd0, done_valid}, 32'd0);
        check("idle_resp_ready", {31'd0, req_ready}, 32'd1);

        // Reset while waiting for COMMAND COMPLETE, then a late response.
        repeat (3) tick();
        req_word = 16'h8123; req_is_query = 1'b1; req_wait_cc = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        eng_word_ready = 1'b1;
        tick();
        eng_word_ready = 1'b0;
        pulse_resp(18'h05555);
        repeat (5) tick();
        check("midrst_in_wait", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        pulse_resp(18'h0FFFF);
        tick();
        check("midrst_late_resp", {30'd0, done_valid, busy}, 32'd0);
        do_txn(tbl[1], tbl[1].e, "post_rst");

        for (int i = 0; i < 40; i++) begin
            v.w = 16'($urandom);
            v.q = ($urandom_range(0, 1) == 1);
            v.wcc = ($urandom_range(0, 1) == 1);
            v.rdy = ($urandom_range(0, 7) != 0);
            v.attn_pre = 1'b0;
            v.r1 = v.q ? {2'b00, 16'($urandom)} : 18'h00000;
            k = $urandom_range(0, 9);
            if (k == 0) v.r1[17] = 1'b1;
            if (k == 1) v.r1[16] = 1'b1;
            k = $urandom_range(0, 4);
            v.mode = (k == 0) ? M_NONE : ((k < 3) ? M_CC : M_ATTN);
            v.dly = $urandom_range(0, 100);
            v.r2 = {2'b00, 16'($urandom)};
            k = $urandom_range(0, 7);
            if (k == 0) v.r2[17] = 1'b1;
            if (k == 1) v.r2[16] = 1'b1;
            do_txn(v, model(v), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
